// File: rtl/ddcb_delay_calibrator_pkg.sv
// Shared types and constants for the delay-cascade calibration controller.
// Holds the legal select-code table and the sweep FSM state encoding.
package ddcb_pkg;

  typedef logic [3:0] sel_code_t;
  typedef logic [2:0] code_idx_t;

  localparam int NUM_CODES = 5;
  localparam code_idx_t LAST_IDX = code_idx_t'(NUM_CODES - 1);

  // Entry 0 is the rightmost element.
  localparam sel_code_t [NUM_CODES-1:0] CODE_TABLE = {4'hF, 4'h7, 4'h3, 4'h2, 4'h0};

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    EVAL,
    DONE
  } cal_state_t;

  function automatic sel_code_t code_at(code_idx_t idx);
    return CODE_TABLE[idx];
  endfunction

endpackage

// File: rtl/ddcb_delay_calibrator_if.sv
// Request, oscillator and result signals of the calibrator.
// The master side is the requester and oscillator model. The slave side is the calibrator.
interface ddcb_delay_calibrator_if
  import ddcb_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             start;
  logic [CNT_W-1:0] target_cnt;
  logic             osc_in;
  logic             osc_en;
  sel_code_t        sel;
  logic             busy;
  logic             done;
  sel_code_t        best_code;
  logic [CNT_W-1:0] best_cnt;
  logic             err;

  modport master (
    output start, target_cnt, osc_in,
    input  osc_en, sel, busy, done, best_code, best_cnt, err
  );

  modport slave (
    input  start, target_cnt, osc_in,
    output osc_en, sel, busy, done, best_code, best_cnt, err
  );

endinterface

// File: rtl/ddcb_delay_calibrator_edge_counter.sv
// Synchronises the async oscillator input, detects rising edges and counts them with saturation.
// An edge reaches the counter 2 cycles after it is sampled. There is no backpressure.
module ddcb_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Bits [1:0] form the synchroniser. Bit [2] is the previous synchronised level.
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             osc_rise;

  always_comb begin
    sync_d   = {sync_q[1:0], osc_in};
    osc_rise = sync_q[1] & ~sync_q[2];
    cnt_d    = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && osc_rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ddcb_delay_calibrator.sv
// Sweeps the five cascade select codes and reports the one whose edge count is closest to the target.
// done fires 1+5*(SETTLE_CYC+WINDOW+1) cycles after start. start is ignored while busy.
module ddcb_delay_calibrator
  import ddcb_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 1024,
  parameter int SETTLE_CYC = 8
) (
  input logic                     clk,
  input logic                     rst,
  ddcb_delay_calibrator_if.slave  bus
);

  localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);

  cal_state_t       state_q, state_d;
  code_idx_t        idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] best_diff_q, best_diff_d;
  logic [CNT_W-1:0] track_cnt_q, track_cnt_d;
  code_idx_t        best_idx_q, best_idx_d;
  logic             any_nz_q, any_nz_d;
  sel_code_t        sel_q, sel_d;
  sel_code_t        best_code_q, best_code_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] meas_cnt;
  logic [CNT_W-1:0] diff;

  ddcb_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk    (clk),
    .rst    (rst),
    .osc_in (bus.osc_in),
    .clr    (state_q == SETTLE),
    .en     (state_q == MEASURE),
    .cnt    (meas_cnt)
  );

  always_comb begin
    diff = (meas_cnt >= target_q) ? (meas_cnt - target_q) : (target_q - meas_cnt);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    target_d    = target_q;
    best_diff_d = best_diff_q;
    track_cnt_d = track_cnt_q;
    best_idx_d  = best_idx_q;
    any_nz_d    = any_nz_q;
    sel_d       = sel_q;
    best_code_d = best_code_q;
    best_cnt_d  = best_cnt_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          target_d    = bus.target_cnt;
          idx_d       = '0;
          tmr_d       = '0;
          best_diff_d = '0;
          track_cnt_d = '0;
          best_idx_d  = '0;
          any_nz_d    = 1'b0;
          sel_d       = code_at('0);
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = MEASURE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      MEASURE: begin
        if (tmr_q == WINDOW_LAST) begin
          tmr_d   = '0;
          state_d = EVAL;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      EVAL: begin
        // Strict compare: on a tie the earlier (lower-index) code is kept.
        if ((idx_q == '0) || (diff < best_diff_q)) begin
          best_diff_d = diff;
          track_cnt_d = meas_cnt;
          best_idx_d  = idx_q;
        end
        any_nz_d = any_nz_q | (meas_cnt != '0);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + code_idx_t'(1);
          sel_d   = code_at(idx_q + code_idx_t'(1));
          state_d = SETTLE;
        end
      end
      DONE: begin
        err_d       = ~any_nz_q;
        best_code_d = any_nz_q ? code_at(best_idx_q) : '0;
        best_cnt_d  = any_nz_q ? track_cnt_q : '0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tmr_q       <= '0;
      target_q    <= '0;
      best_diff_q <= '0;
      track_cnt_q <= '0;
      best_idx_q  <= '0;
      any_nz_q    <= 1'b0;
      sel_q       <= '0;
      best_code_q <= '0;
      best_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      target_q    <= target_d;
      best_diff_q <= best_diff_d;
      track_cnt_q <= track_cnt_d;
      best_idx_q  <= best_idx_d;
      any_nz_q    <= any_nz_d;
      sel_q       <= sel_d;
      best_code_q <= best_code_d;
      best_cnt_q  <= best_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.osc_en    = (state_q == SETTLE) || (state_q == MEASURE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.sel       = sel_q;
  assign bus.best_code = best_code_q;
  assign bus.best_cnt  = best_cnt_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ddcb_delay_calibrator.sv
// Randomised and directed bench for ddcb_delay_calibrator with a clocked oscillator model and an edge-history reference.
// The reference recounts recorded oscillator edges per measurement window and picks the closest code.
module tb_ddcb_delay_calibrator;
  import ddcb_pkg::*;

  localparam int W   = 64;
  localparam int S   = 4;
  localparam int LAT = 1 + 5 * (S + W + 1);
  localparam int HN  = 16384;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ddcb_delay_calibrator_if #(.CNT_W(16)) b0 ();
  ddcb_delay_calibrator_if #(.CNT_W(4))  b1 ();

  ddcb_delay_calibrator #(.CNT_W(16), .WINDOW(W), .SETTLE_CYC(S)) dut0 (
    .clk (clk), .rst (rst), .bus (b0)
  );
  ddcb_delay_calibrator #(.CNT_W(4), .WINDOW(W), .SETTLE_CYC(S)) dut1 (
    .clk (clk), .rst (rst), .bus (b1)
  );

  int        checks = 0;
  int        errors = 0;
  int        cyc    = 0;
  bit        hist [2][HN];
  int        per  [5];
  sel_code_t tab  [5];
  bit        stuck = 1'b0;

  // Oscillator model: the period follows the live select code and is gated by osc_en.
  initial begin
    int p;
    b0.osc_in = 1'b0;
    b1.osc_in = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      p = 4;
      for (int i = 0; i < 5; i++) if (b0.sel === tab[i]) p = per[i];
      b0.osc_in = b0.osc_en && !stuck && ((cyc % p) < (p / 2));
      b1.osc_in = b1.osc_en && ((cyc % 2) == 0);
      hist[0][cyc % HN] = b0.osc_in;
      hist[1][cyc % HN] = b1.osc_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rising edges seen in cycle k are counted if k+2 lies in the measurement window.
  function automatic int model_cnt(input int d, input int ws, input int cw);
    int n;
    int mx;
    n  = 0;
    mx = (1 << cw) - 1;
    for (int k = ws - 2; k <= ws + W - 3; k++)
      if (hist[d][k % HN] && !hist[d][(k - 1) % HN]) n++;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_sweep(input int d, input int t0, input int cw, input int tgt,
                             output int code, output int cnt, output bit er);
    int c [5];
    int best;
    int bd;
    int dif;
    bit any;
    best = 0;
    bd   = 0;
    any  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c[i] = model_cnt(d, t0 + 1 + S + i * (S + W + 1), cw);
      if (c[i] != 0) any = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      dif = (c[i] > tgt) ? c[i] - tgt : tgt - c[i];
      if (i == 0 || dif < bd) begin
        bd   = dif;
        best = i;
      end
    end
    er   = !any;
    code = any ? int'(tab[best]) : 0;
    cnt  = any ? c[best] : 0;
  endtask

  task automatic sweep0(input int tgt, input bit dbl, input string tag);
    int t0, tdone, busy_bad, mc, mn;
    bit me;
    b0.target_cnt = 16'(tgt);
    b0.start      = 1'b1;
    t0            = cyc;
    tick();
    b0.start      = 1'b0;
    b0.target_cnt = 16'($urandom);
    tdone         = -1;
    busy_bad      = 0;
    for (int i = 0; i < LAT + 20 && tdone < 0; i++) begin
      if (b0.busy !== 1'b1) busy_bad++;
      if (b0.done === 1'b1) begin
        tdone = cyc;
      end else begin
        b0.start = (dbl && cyc == t0 + 10);
        tick();
      end
    end
    b0.start = 1'b0;
    chk({tag, " latency"}, tdone - t0, LAT);
    chk({tag, " busy_window"}, busy_bad, 0);
    tick();
    chk({tag, " done_pulse"}, b0.done, 0);
    chk({tag, " busy_after"}, b0.busy, 0);
    model_sweep(0, t0, 16, tgt, mc, mn, me);
    chk({tag, " best_code"}, b0.best_code, mc);
    chk({tag, " best_cnt"}, b0.best_cnt, mn);
    chk({tag, " err"}, b0.err, me);
  endtask

  initial begin
    int t0, tdone, bad, mc, mn;
    bit me;
    tab[0] = 4'h0; tab[1] = 4'h2; tab[2] = 4'h3; tab[3] = 4'h7; tab[4] = 4'hF;
    per[0] = 4; per[1] = 5; per[2] = 6; per[3] = 7; per[4] = 8;
    rst = 1'b1;
    b0.start = 1'b0; b0.target_cnt = '0;
    b1.start = 1'b0; b1.target_cnt = '0;
    repeat (3) tick();
    chk("rst osc_en", b0.osc_en, 0);
    chk("rst sel", b0.sel, 0);
    chk("rst busy", b0.busy, 0);
    chk("rst done", b0.done, 0);
    chk("rst best_code", b0.best_code, 0);
    chk("rst best_cnt", b0.best_cnt, 0);
    chk("rst err", b0.err, 0);
    rst = 1'b0;
    tick();

    sweep0(8, 1'b0, "acc8");
    chk("acc8 code_F", b0.best_code, 4'hF);
    chk("acc8 cnt_8", b0.best_cnt, 8);
    sweep0(16, 1'b0, "acc16");
    chk("acc16 code_0", b0.best_code, 4'h0);
    chk("acc16 cnt_16", b0.best_cnt, 16);

    sweep0(12, 1'b1, "dblstart");

    for (int i = 0; i < 5; i++) per[i] = 4;
    sweep0(0, 1'b0, "tie");
    chk("tie code_0", b0.best_code, 4'h0);
    chk("tie cnt_16", b0.best_cnt, 16);

    stuck = 1'b1;
    sweep0(5, 1'b0, "stuck");
    chk("stuck err_1", b0.err, 1);
    chk("stuck cnt_0", b0.best_cnt, 0);
    stuck = 1'b0;
    per[0] = 4; per[1] = 5; per[2] = 6; per[3] = 7; per[4] = 8;
    sweep0(10, 1'b0, "recover");
    chk("recover err_0", b0.err, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) per[i] = $urandom_range(10, 4);
      sweep0($urandom_range(20, 0), 1'b0, "rand");
    end

    // Reset during the third code's measurement window.
    b0.target_cnt = 16'd9;
    b0.start      = 1'b1;
    t0            = cyc;
    tick();
    b0.start = 1'b0;
    for (int i = 0; i < 400 && cyc < t0 + 160; i++) tick();
    chk("mid sel_3", b0.sel, 4'h3);
    chk("mid osc_en", b0.osc_en, 1);
    rst = 1'b1;
    #1;
    chk("arst osc_en", b0.osc_en, 0);
    chk("arst busy", b0.busy, 0);
    chk("arst sel", b0.sel, 0);
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (b0.done !== 1'b0 || b0.busy !== 1'b0) bad++;
      tick();
    end
    chk("arst no_done", bad, 0);
    chk("arst best_cnt", b0.best_cnt, 0);
    sweep0($urandom_range(16, 8), 1'b0, "after_rst");

    // Saturating instance: period-2 oscillator overflows the 4-bit counter.
    b1.target_cnt = 4'd15;
    b1.start      = 1'b1;
    t0            = cyc;
    tick();
    b1.start = 1'b0;
    tdone    = -1;
    for (int i = 0; i < LAT + 20 && tdone < 0; i++) begin
      if (b1.done === 1'b1) tdone = cyc;
      else tick();
    end
    chk("sat latency", tdone - t0, LAT);
    tick();
    model_sweep(1, t0, 4, 15, mc, mn, me);
    chk("sat best_code", b1.best_code, mc);
    chk("sat best_cnt", b1.best_cnt, mn);
    chk("sat code_0", b1.best_code, 4'h0);
    chk("sat cnt_15", b1.best_cnt, 15);
    chk("sat err", b1.err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
